// File: rtl/jtkunio_sndcmd.sv
// Main-to-sound command transmitter: FIFO-buffers main CPU command bytes and hands them to the
// sound CPU one at a time through a latch + IRQ pulse, waiting for the latch-read acknowledge.
module jtkunio_sndcmd #(
  parameter int unsigned AW        = 2,
  parameter int unsigned PULSE_LEN = 8,
  parameter int unsigned GAP_LEN   = 16,
  parameter int unsigned RETRY     = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_we,
  input  logic [7:0]    cmd_din,
  output logic          cmd_full,
  output logic [AW:0]   cmd_level,
  output logic          cmd_ovf,
  input  logic          ovf_clr,
  output logic          busy,
  output logic [7:0]    snd_latch,
  output logic          snd_irq,
  input  logic          snd_rd
);

  localparam int unsigned Depth   = 2 ** AW;
  localparam logic [AW:0] DepthW  = (AW + 1)'(Depth);
  localparam logic [15:0] PulseLd = 16'(PULSE_LEN - 1);
  localparam logic [15:0] GapLd   = (GAP_LEN == 0) ? 16'd0 : 16'(GAP_LEN - 1);
  localparam logic [15:0] RetryLd = (RETRY == 0) ? 16'd0 : 16'(RETRY - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StWaitAck, StGap} state_e;

  // With no gap configured the acknowledge returns straight to idle.
  localparam state_e AckNext = (GAP_LEN == 0) ? StIdle : StGap;

  state_e        state_q;
  logic [15:0]   timer_q;
  logic [7:0]    mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_q;
  logic [7:0]    latch_q;
  logic          full, pop, push, drop;

  always_comb begin
    full    = (count_q == DepthW);
    pop     = (state_q == StIdle) && (count_q != '0);
    push    = cmd_we && (!full || pop);
    drop    = cmd_we && full && !pop;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_clr ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      timer_q  <= '0;
      latch_q  <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            latch_q <= mem_q[rd_ptr_q];
            irq_q   <= 1'b1;
            timer_q <= PulseLd;
            state_q <= StPulse;
          end
        end
        StPulse: begin
          if (snd_rd) begin
            irq_q   <= 1'b0;
            timer_q <= GapLd;
            state_q <= AckNext;
          end else if (timer_q == '0) begin
            irq_q   <= 1'b0;
            timer_q <= RetryLd;
            state_q <= StWaitAck;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        StWaitAck: begin
          if (snd_rd) begin
            timer_q <= GapLd;
            state_q <= AckNext;
          end else if ((RETRY != 0) && (timer_q == '0)) begin
            // Re-announce the same byte; the latch is left untouched.
            irq_q   <= 1'b1;
            timer_q <= PulseLd;
            state_q <= StPulse;
          end else if (timer_q != '0) begin
            timer_q <= timer_q - 16'd1;
          end
        end
        StGap: begin
          if (timer_q == '0) begin
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_full  = full;
  assign cmd_level = count_q;
  assign cmd_ovf   = ovf_q;
  assign busy      = (state_q != StIdle) || (count_q != '0);
  assign snd_latch = latch_q;
  assign snd_irq   = irq_q;

endmodule

// File: tb/tb_jtkunio_sndcmd.sv
// Directed bench for jtkunio_sndcmd: a default instance plus one with RETRY = 100.
module tb_jtkunio_sndcmd;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_we, ovf_clr, snd_rd;
  logic [7:0] cmd_din;
  logic       cmd_full, cmd_ovf, busy, snd_irq;
  logic [2:0] cmd_level;
  logic [7:0] snd_latch;

  logic       r_we, r_ovf_clr, r_rd;
  logic [7:0] r_din;
  logic       r_full, r_ovf, r_busy, r_irq;
  logic [2:0] r_level;
  logic [7:0] r_latch;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtkunio_sndcmd u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_we    (cmd_we),
    .cmd_din   (cmd_din),
    .cmd_full  (cmd_full),
    .cmd_level (cmd_level),
    .cmd_ovf   (cmd_ovf),
    .ovf_clr   (ovf_clr),
    .busy      (busy),
    .snd_latch (snd_latch),
    .snd_irq   (snd_irq),
    .snd_rd    (snd_rd)
  );

  jtkunio_sndcmd #(.RETRY(100)) u_dut_r (
    .clk       (clk),
    .rst       (rst),
    .cmd_we    (r_we),
    .cmd_din   (r_din),
    .cmd_full  (r_full),
    .cmd_level (r_level),
    .cmd_ovf   (r_ovf),
    .ovf_clr   (r_ovf_clr),
    .busy      (r_busy),
    .snd_latch (r_latch),
    .snd_irq   (r_irq),
    .snd_rd    (r_rd)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_we = 1'b0; ovf_clr = 1'b0; snd_rd = 1'b0; cmd_din = 8'h00;
    r_we = 1'b0; r_ovf_clr = 1'b0; r_rd = 1'b0; r_din = 8'h00;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({snd_latch, snd_irq, cmd_full, cmd_level, cmd_ovf, busy} !== 14'h0) begin
      errors++;
      $display("FAIL reset_state: got latch=%h irq=%b full=%b level=%0d ovf=%b busy=%b, want all 0",
               snd_latch, snd_irq, cmd_full, cmd_level, cmd_ovf, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    cmd_we = 1'b1; cmd_din = 8'h5A;
    tick(1);
    cmd_we = 1'b0;
    checks++;
    if (cmd_level !== 3'd1 || snd_irq !== 1'b0) begin
      errors++;
      $display("FAIL single_write: got level=%0d irq=%b, want level=1 irq=0", cmd_level, snd_irq);
    end
    tick(1);
    checks++;
    if (snd_latch !== 8'h5A || snd_irq !== 1'b1 || cmd_level !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_present: got latch=%h irq=%b level=%0d busy=%b, want 5a 1 0 1",
               snd_latch, snd_irq, cmd_level, busy);
    end
    tick(7);
    checks++;
    if (snd_irq !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse_hold: got irq=%b, want 1", snd_irq);
    end
    tick(1);
    checks++;
    if (snd_irq !== 1'b0 || snd_latch !== 8'h5A) begin
      errors++;
      $display("FAIL single_pulse_end: got irq=%b latch=%h, want 0 5a", snd_irq, snd_latch);
    end
  endtask

  task automatic test_burst();
    int   nseen = 0;
    int   rise_edge = -1000;
    int   ack_edge = -1;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cmd_we = 1'b0; snd_rd = 1'b0;
      if (snd_irq && !prev) begin
        nseen++;
        rise_edge = cyc;
        checks++;
        if (snd_latch !== 8'(nseen) || cmd_ovf !== 1'b0) begin
          errors++;
          $display("FAIL burst_order: got latch=%h ovf=%b, want %h 0", snd_latch, cmd_ovf,
                   8'(nseen));
        end
        if (nseen > 1) begin
          checks++;
          if (rise_edge - ack_edge !== 17) begin
            errors++;
            $display("FAIL burst_ack_to_rise: got %0d cycles, want 17", rise_edge - ack_edge);
          end
        end
      end
      prev = snd_irq;
      if (i < 5) begin
        cmd_we = 1'b1; cmd_din = 8'(i + 1);
      end
      if (cyc == rise_edge + 39) begin
        snd_rd = 1'b1;
        ack_edge = cyc + 1;
      end
    end
    checks++;
    if (nseen !== 5) begin
      errors++;
      $display("FAIL burst_count: got %0d presentations, want 5", nseen);
    end
    checks++;
    if (busy !== 1'b0 || cmd_ovf !== 1'b0 || cmd_level !== 3'd0) begin
      errors++;
      $display("FAIL burst_drain: got busy=%b ovf=%b level=%0d, want 0 0 0", busy, cmd_ovf,
               cmd_level);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cmd_we = 1'b1; cmd_din = 8'(8'h10 + i);
      tick(1);
      if (i == 4) begin
        checks++;
        if (cmd_full !== 1'b1 || cmd_level !== 3'd4 || cmd_ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_fill: got full=%b level=%0d ovf=%b, want 1 4 0", cmd_full,
                   cmd_level, cmd_ovf);
        end
      end
    end
    cmd_we = 1'b0;
    checks++;
    if (cmd_ovf !== 1'b1 || cmd_level !== 3'd4 || snd_latch !== 8'h10) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b level=%0d latch=%h, want 1 4 10", cmd_ovf, cmd_level,
               snd_latch);
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    checks++;
    if (cmd_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b, want 0", cmd_ovf);
    end
    cmd_we = 1'b1; cmd_din = 8'hEE; ovf_clr = 1'b1;
    tick(1);
    cmd_we = 1'b0; ovf_clr = 1'b0;
    checks++;
    if (cmd_ovf !== 1'b0 || cmd_level !== 3'd4) begin
      errors++;
      $display("FAIL ovf_clr_priority: got ovf=%b level=%0d, want 0 4", cmd_ovf, cmd_level);
    end
    cmd_we = 1'b1;
    tick(1);
    cmd_we = 1'b0;
    checks++;
    if (cmd_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_reset_again: got ovf=%b, want 1", cmd_ovf);
    end
  endtask

  task automatic test_early_ack_retry();
    do_reset();
    r_we = 1'b1; r_din = 8'hAA;
    tick(1);
    r_we = 1'b0;
    tick(1);
    checks++;
    if (r_irq !== 1'b1 || r_latch !== 8'hAA) begin
      errors++;
      $display("FAIL retry_first_rise: got irq=%b latch=%h, want 1 aa", r_irq, r_latch);
    end
    tick(2);
    checks++;
    if (r_irq !== 1'b1) begin
      errors++;
      $display("FAIL early_ack_before: got irq=%b, want 1", r_irq);
    end
    r_rd = 1'b1;
    tick(1);
    r_rd = 1'b0;
    checks++;
    if (r_irq !== 1'b0) begin
      errors++;
      $display("FAIL early_ack_fall: got irq=%b, want 0", r_irq);
    end
    r_we = 1'b1; r_din = 8'hBB;
    tick(1);
    r_din = 8'hCC;
    tick(1);
    r_we = 1'b0;
    tick(15);
    checks++;
    if (r_irq !== 1'b1 || r_latch !== 8'hBB || r_level !== 3'd1) begin
      errors++;
      $display("FAIL retry_second_rise: got irq=%b latch=%h level=%0d, want 1 bb 1", r_irq,
               r_latch, r_level);
    end
    tick(7);
    checks++;
    if (r_irq !== 1'b1) begin
      errors++;
      $display("FAIL retry_pulse_hold: got irq=%b, want 1", r_irq);
    end
    tick(1);
    checks++;
    if (r_irq !== 1'b0) begin
      errors++;
      $display("FAIL retry_pulse_end: got irq=%b, want 0", r_irq);
    end
    tick(99);
    checks++;
    if (r_irq !== 1'b0) begin
      errors++;
      $display("FAIL retry_wait: got irq=%b, want 0", r_irq);
    end
    tick(1);
    checks++;
    if (r_irq !== 1'b1 || r_latch !== 8'hBB || r_level !== 3'd1) begin
      errors++;
      $display("FAIL retry_rerise: got irq=%b latch=%h level=%0d, want 1 bb 1", r_irq, r_latch,
               r_level);
    end
  endtask

  task automatic test_reset_midway();
    int   rises = 0;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd_we = 1'b1; cmd_din = 8'(8'h30 + i);
      tick(1);
    end
    cmd_we = 1'b0;
    tick(12);
    checks++;
    if (snd_irq !== 1'b0 || cmd_level !== 3'd3 || snd_latch !== 8'h30) begin
      errors++;
      $display("FAIL midreset_pre: got irq=%b level=%0d latch=%h, want 0 3 30", snd_irq,
               cmd_level, snd_latch);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({snd_latch, snd_irq, cmd_full, cmd_level, cmd_ovf, busy} !== 14'h0) begin
      errors++;
      $display("FAIL midreset_state: got latch=%h irq=%b full=%b level=%0d ovf=%b busy=%b",
               snd_latch, snd_irq, cmd_full, cmd_level, cmd_ovf, busy);
    end
    cmd_we = 1'b1; cmd_din = 8'h77;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      cmd_we = 1'b0;
      if (snd_irq && !prev) rises++;
      prev = snd_irq;
    end
    checks++;
    if (rises !== 1 || snd_latch !== 8'h77 || cmd_level !== 3'd0) begin
      errors++;
      $display("FAIL midreset_after: got rises=%0d latch=%h level=%0d, want 1 77 0", rises,
               snd_latch, cmd_level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_early_ack_retry();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
